// File: rtl/sv_serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Define SV_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module sv_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SV_SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  baud_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              bit_end;
  logic [DATA_W-1:0] shifted;
`ifdef SV_SERIAL_TX_PARITY_EN
  logic              parity_bit;
`endif

  always_comb begin
    bit_end = (baud_cnt == CNT_LAST);
    shifted = shift_reg >> 1;
  end

  // Outputs are registered alongside the state they belong to, so tx never
  // sees a combinational path from the input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
`ifdef SV_SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state      <= START;
            shift_reg  <= in_data;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            tx         <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
`ifdef SV_SERIAL_TX_PARITY_EN
            parity_bit <= ^in_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= shifted;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef SV_SERIAL_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shifted[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef SV_SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
            tx       <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
